// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// default latencies and small op-classification helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W           = 16;

  function automatic logic op_valid(input logic [2:0] op);
    logic v;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD: v = 1'b1;
      default:                                     v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    logic v;
    case (op)
      OP_DIV, OP_DIVU: v = 1'b1;
      default:         v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational 64-bit datapath: signed/unsigned multiply, multiply-accumulate
// and signed/unsigned divide. Divide by zero passes HI/LO through unchanged.
module mdu_core
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0]        sprod_s;
  logic [63:0]        uprod_s;
  logic [63:0]        macc_s;
  logic               b_zero_s;
  logic               sdiv_ovf_s;
  logic [31:0]        udiv_b_s;
  logic signed [31:0] sdiv_b_s;
  logic signed [31:0] sq_s;
  logic signed [31:0] sr_s;
  logic [31:0]        uq_s;
  logic [31:0]        ur_s;

  // Arithmetic and result selection; the INT_MIN / -1 case divides by 1 instead,
  // which yields the wrapped quotient 0x80000000 and remainder 0.
  always_comb begin
    sprod_s    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    uprod_s    = {32'h0000_0000, a} * {32'h0000_0000, b};
    macc_s     = {hi_in, lo_in} + sprod_s;
    b_zero_s   = (b == 32'h0000_0000);
    sdiv_ovf_s = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    udiv_b_s   = b_zero_s ? 32'h0000_0001 : b;
    sdiv_b_s   = (b_zero_s || sdiv_ovf_s) ? 32'sh0000_0001 : $signed(b);
    sq_s       = $signed(a) / sdiv_b_s;
    sr_s       = $signed(a) % sdiv_b_s;
    uq_s       = a / udiv_b_s;
    ur_s       = a % udiv_b_s;
    div_zero   = op_is_div(op) && b_zero_s;
    res_hi     = hi_in;
    res_lo     = lo_in;
    case (op)
      OP_MULT:  begin res_hi = sprod_s[63:32]; res_lo = sprod_s[31:0]; end
      OP_MULTU: begin res_hi = uprod_s[63:32]; res_lo = uprod_s[31:0]; end
      OP_MADD:  begin res_hi = macc_s[63:32];  res_lo = macc_s[31:0];  end
      OP_DIV: begin
        if (b_zero_s) begin
          res_hi = hi_in;
          res_lo = lo_in;
        end else begin
          res_hi = sr_s;
          res_lo = sq_s;
        end
      end
      OP_DIVU: begin
        if (b_zero_s) begin
          res_hi = hi_in;
          res_lo = lo_in;
        end else begin
          res_hi = ur_s;
          res_lo = uq_s;
        end
      end
      default: begin res_hi = hi_in; res_lo = lo_in; end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: IDLE/RUN FSM with a latency counter, operand
// latches and the architectural HI/LO registers.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e       state_r;
  mdu_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_load_s;
  logic [31:0]      a_r;
  logic [31:0]      b_r;
  logic [2:0]       op_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic             done_r;
  logic             accept_s;
  logic             finish_s;
  logic             do_wr_hi_s;
  logic             do_wr_lo_s;
  logic [31:0]      res_hi_s;
  logic [31:0]      res_lo_s;
  logic             div_zero_s;

  mdu_core u_core (
    .a        (a_r),
    .b        (b_r),
    .op       (op_r),
    .hi_in    (hi_r),
    .lo_in    (lo_r),
    .res_hi   (res_hi_s),
    .res_lo   (res_lo_s),
    .div_zero (div_zero_s)
  );

  // Issue/complete decode and next-state; a valid start wins over mthi/mtlo.
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && start && !cancel && op_valid(op);
    finish_s    = (state_r == ST_RUN) && (cnt_r == CNT_W'(1));
    do_wr_hi_s  = (state_r == ST_IDLE) && wr_hi && !cancel && !accept_s;
    do_wr_lo_s  = (state_r == ST_IDLE) && wr_lo && !cancel && !accept_s;
    cnt_load_s  = op_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (finish_s) state_nxt_s = ST_IDLE;
        else          state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, counter, operand latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      a_r     <= 32'h0000_0000;
      b_r     <= 32'h0000_0000;
      op_r    <= 3'b000;
      hi_r    <= 32'h0000_0000;
      lo_r    <= 32'h0000_0000;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= finish_s;
      if (accept_s) begin
        a_r   <= src_a;
        b_r   <= src_b;
        op_r  <= op;
        cnt_r <= cnt_load_s;
      end else if (state_r == ST_RUN) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
      if (finish_s && !div_zero_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end else begin
        if (do_wr_hi_s) hi_r <= wr_data;
        if (do_wr_lo_s) lo_r <= wr_data;
      end
    end
  end

  assign busy = (state_r == ST_RUN);
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: inputs change on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  int n;

  mdu_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .cancel  (cancel),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present a start for one rising edge; returns at the next falling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count falling edges with busy high, bounded so a stuck FSM still terminates.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'b000; src_a = 32'h0; src_b = 32'h0;
    cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

    // signed multiply -2 * 3
    issue(3'b000, 32'hFFFF_FFFE, 32'h3);
    wait_idle(n);
    check("mult_busy_cycles", n, 32'd5);
    check("mult_done", {31'h0, done}, 32'h1);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    @(negedge clk);
    check("mult_done_pulse", {31'h0, done}, 32'h0);

    // unsigned multiply of the same operands
    issue(3'b001, 32'hFFFF_FFFE, 32'h3);
    wait_idle(n);
    check("multu_busy_cycles", n, 32'd5);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    issue(3'b011, 32'd100, 32'd7);
    wait_idle(n);
    check("divu_busy_cycles", n, 32'd10);
    check("divu_done", {31'h0, done}, 32'h1);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    issue(3'b010, 32'hFFFF_FFF9, 32'h2);
    wait_idle(n);
    check("div_busy_cycles", n, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // mthi / mtlo, then divide by zero must leave them untouched
    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'h1234;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h5678;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mthi", hi, 32'h1234);
    check("mtlo", lo, 32'h5678);
    issue(3'b010, 32'd55, 32'd0);
    wait_idle(n);
    check("div0_busy_cycles", n, 32'd10);
    check("div0_done", {31'h0, done}, 32'h1);
    check("div0_hi", hi, 32'h1234);
    check("div0_lo", lo, 32'h5678);

    // both strobes at once, then madd with start and wr_hi ignored in RUN
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0;
    @(negedge clk);
    wr_hi = 1'b0; wr_data = 32'hFFFF_FFFF;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mt_both_hi", hi, 32'h0);
    check("mt_lo_ff", lo, 32'hFFFF_FFFF);
    issue(3'b100, 32'd1, 32'd1);
    start = 1'b1; op = 3'b000; src_a = 32'd5; src_b = 32'd5;
    wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    wait_idle(n);
    check("madd_busy_cycles", n + 1, 32'd5);
    check("madd_done", {31'h0, done}, 32'h1);
    check("madd_hi", hi, 32'h1);
    check("madd_lo", lo, 32'h0);

    // back-to-back start while done is high
    issue(3'b001, 32'd2, 32'd3);
    check("b2b_busy", {31'h0, busy}, 32'h1);
    check("b2b_done_low", {31'h0, done}, 32'h0);
    wait_idle(n);
    check("b2b_busy_cycles", n, 32'd5);
    check("b2b_hi", hi, 32'h0);
    check("b2b_lo", lo, 32'd6);

    // reset in the third RUN cycle of a mult
    @(negedge clk);
    issue(3'b000, 32'd3, 32'd3);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstrun_busy", {31'h0, busy}, 32'h0);
    check("rstrun_done", {31'h0, done}, 32'h0);
    check("rstrun_hi", hi, 32'h0);
    check("rstrun_lo", lo, 32'h0);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    check("rstrun_no_done", n, 32'd0);

    // cancelled start, invalid op, cancelled mtlo
    start = 1'b1; cancel = 1'b1; op = 3'b000; src_a = 32'd4; src_b = 32'd4;
    wr_lo = 1'b1; wr_data = 32'h7777;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; wr_lo = 1'b0;
    check("cancel_busy", {31'h0, busy}, 32'h0);
    check("cancel_mtlo", lo, 32'h0);
    issue(3'b101, 32'd4, 32'd4);
    check("badop_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    check("badop_busy2", {31'h0, busy}, 32'h0);
    check("badop_done", {31'h0, done}, 32'h0);

    // start wins over a same-cycle mthi
    wr_hi = 1'b1; wr_data = 32'hAAAA_AAAA;
    issue(3'b000, 32'd2, 32'd2);
    wr_hi = 1'b0;
    check("startwin_busy", {31'h0, busy}, 32'h1);
    check("startwin_hi", hi, 32'h0);
    wait_idle(n);
    check("startwin_lo", lo, 32'd4);
    check("startwin_hi_end", hi, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
